// File: rtl/axis_icap_writer.sv
// AXI4-Stream to ICAPE2/ICAPE3 write-port sequencer: one tlast-delimited frame per partial bitstream.
// Optional sync-word gating is built when AXIS_ICAP_SYNC_DETECT_EN is defined.
module axis_icap_writer #(
    parameter int BIT_SWAP  = 1,
    parameter int CNT_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [31:0]          s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic                 s_axis_tlast,
    input  logic                 s_axis_tuser,
    output logic                 icap_csib,
    output logic                 icap_rdwrb,
    output logic [31:0]          icap_i,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [CNT_WIDTH-1:0] word_count
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_WRITE    = 3'd2,
        ST_FLUSH    = 3'd3,
        ST_TEARDOWN = 3'd4
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // ICAP expects each configuration byte bit-reversed.
    function automatic logic [31:0] byte_bit_swap(input logic [31:0] din);
        logic [31:0] dout;
        dout = 32'd0;
        for (int k = 0; k < 4; k++) begin
            for (int b = 0; b < 8; b++) begin
                dout[8*k+b] = din[8*k+7-b];
            end
        end
        return dout;
    endfunction

    state_t               state_q, state_d;
    logic                 csib_q, csib_d;
    logic                 rdwrb_q, rdwrb_d;
    logic [31:0]          icap_q, icap_d;
    logic [CNT_WIDTH-1:0] wcnt_q, wcnt_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;
    logic                 good_q, good_d;
    logic                 tready_s;
    logic                 hs_s;
    logic                 write_ok_s;
    logic [31:0]          swapped_s;

`ifdef AXIS_ICAP_SYNC_DETECT_EN
    localparam logic [31:0] SYNC_WORD = 32'hAA995566;
    logic                 sync_q, sync_d;
`endif

    assign tready_s = (state_q == ST_WRITE) || (state_q == ST_FLUSH);
    assign hs_s     = s_axis_tvalid && tready_s;

    // Data path: optional per-byte bit reversal of the incoming word.
    always_comb begin
        swapped_s = s_axis_tdata;
        if (BIT_SWAP != 0) begin
            swapped_s = byte_bit_swap(s_axis_tdata);
        end else begin
            swapped_s = s_axis_tdata;
        end
    end

    // Decides whether a clean WRITE beat reaches the ICAP.
    always_comb begin
        write_ok_s = 1'b1;
`ifdef AXIS_ICAP_SYNC_DETECT_EN
        sync_d = sync_q;
        if (state_q == ST_SETUP) begin
            sync_d = 1'b0;
        end else if (state_q == ST_WRITE && hs_s && !s_axis_tuser) begin
            write_ok_s = sync_q || (s_axis_tdata == SYNC_WORD);
            sync_d     = sync_q || (s_axis_tdata == SYNC_WORD);
        end else begin
            sync_d = sync_q;
        end
`endif
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d = state_q;
        csib_d  = csib_q;
        rdwrb_d = rdwrb_q;
        icap_d  = icap_q;
        wcnt_d  = wcnt_q;
        good_d  = good_q;
        done_d  = 1'b0;
        error_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                csib_d  = 1'b1;
                rdwrb_d = 1'b1;
                if (enable && s_axis_tvalid) begin
                    state_d = ST_SETUP;
                    rdwrb_d = 1'b0;
                    wcnt_d  = {CNT_WIDTH{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                csib_d  = 1'b1;
                rdwrb_d = 1'b0;
                good_d  = 1'b1;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                csib_d = 1'b1;
                if (hs_s && s_axis_tuser) begin
                    good_d  = 1'b0;
                    state_d = s_axis_tlast ? ST_TEARDOWN : ST_FLUSH;
                end else if (hs_s) begin
                    if (write_ok_s) begin
                        csib_d = 1'b0;
                        icap_d = swapped_s;
                        wcnt_d = (wcnt_q == CNT_MAX) ? wcnt_q : (wcnt_q + CNT_ONE);
                    end else begin
                        csib_d = 1'b1;
                    end
                    if (s_axis_tlast) begin
                        good_d  = write_ok_s;
                        state_d = ST_TEARDOWN;
                    end else begin
                        state_d = ST_WRITE;
                    end
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_FLUSH: begin
                csib_d = 1'b1;
                if (hs_s && s_axis_tlast) begin
                    good_d  = 1'b0;
                    state_d = ST_TEARDOWN;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            ST_TEARDOWN: begin
                // Last word is on the port this cycle; release both strobes together.
                csib_d  = 1'b1;
                rdwrb_d = 1'b1;
                done_d  = good_q;
                error_d = !good_q;
                state_d = ST_IDLE;
            end
            default: begin
                csib_d  = 1'b1;
                rdwrb_d = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            csib_q  <= 1'b1;
            rdwrb_q <= 1'b1;
            icap_q  <= 32'd0;
            wcnt_q  <= {CNT_WIDTH{1'b0}};
            done_q  <= 1'b0;
            error_q <= 1'b0;
            good_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            csib_q  <= csib_d;
            rdwrb_q <= rdwrb_d;
            icap_q  <= icap_d;
            wcnt_q  <= wcnt_d;
            done_q  <= done_d;
            error_q <= error_d;
            good_q  <= good_d;
        end
    end

`ifdef AXIS_ICAP_SYNC_DETECT_EN
    // Sync-found flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
        end
    end
`endif

    assign s_axis_tready = tready_s;
    assign icap_csib     = csib_q;
    assign icap_rdwrb    = rdwrb_q;
    assign icap_i        = icap_q;
    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;
    assign error         = error_q;
    assign word_count    = wcnt_q;

endmodule

// File: tb/tb_axis_icap_writer.sv
// Directed self-checking bench for axis_icap_writer (BIT_SWAP=1, CNT_WIDTH=24).
module tb_axis_icap_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic        s_axis_tuser;
    logic        icap_csib;
    logic        icap_rdwrb;
    logic [31:0] icap_i;
    logic        busy;
    logic        done;
    logic        error;
    logic [23:0] word_count;

    int checks = 0;
    int errors = 0;

    int          cyc = 0;
    logic [31:0] wq[$];
    int          wcyc[$];
    int          n_done, n_err, viol, ready_seen, done_cyc;

    axis_icap_writer #(.BIT_SWAP(1), .CNT_WIDTH(24)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .s_axis_tuser(s_axis_tuser), .icap_csib(icap_csib),
        .icap_rdwrb(icap_rdwrb), .icap_i(icap_i), .busy(busy),
        .done(done), .error(error), .word_count(word_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe the ICAP port mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (!icap_csib) begin
                wq.push_back(icap_i);
                wcyc.push_back(cyc);
                if (icap_rdwrb) viol++;
            end
            if (s_axis_tready && icap_rdwrb) viol++;
            if (s_axis_tready) ready_seen++;
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (error) n_err++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wq.delete();
        wcyc.delete();
        n_done = 0;
        n_err = 0;
        viol = 0;
        ready_seen = 0;
        done_cyc = -1;
    endtask

    task automatic send_beat(input logic [31:0] data, input logic last, input logic user);
        logic got;
        got = 1'b0;
        s_axis_tdata  = data;
        s_axis_tlast  = last;
        s_axis_tuser  = user;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = s_axis_tready;
            @(posedge clk);
            #1;
        end
        if (!got) check_eq("hs_timeout", 32'd0, 32'd1);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
    endtask

    task automatic start_checked(input logic [31:0] data);
        s_axis_tdata  = data;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        s_axis_tvalid = 1'b1;
        enable        = 1'b1;
        tick();
        check_eq("setup_busy",   32'(busy), 32'd1);
        check_eq("setup_tready", 32'(s_axis_tready), 32'd0);
        check_eq("setup_csib",   32'(icap_csib), 32'd1);
        check_eq("setup_rdwrb",  32'(icap_rdwrb), 32'd0);
        tick();
        check_eq("write_tready", 32'(s_axis_tready), 32'd1);
    endtask

    task automatic clean_frame(input string tag);
        send_beat(32'h01020304, 1'b0, 1'b0);
        send_beat(32'h05060708, 1'b0, 1'b0);
        send_beat(32'h090A0B0C, 1'b0, 1'b0);
        send_beat(32'h0000000F, 1'b1, 1'b0);
        repeat (4) tick();
        check_eq({tag, "_nw"}, 32'(wq.size()), 32'd4);
        if (wq.size() == 4) begin
            check_eq({tag, "_w0"}, wq[0], 32'h8040C020);
            check_eq({tag, "_w1"}, wq[1], 32'hA060E010);
            check_eq({tag, "_w2"}, wq[2], 32'h9050D030);
            check_eq({tag, "_w3"}, wq[3], 32'h000000F0);
            check_eq({tag, "_done_lat"}, 32'(done_cyc), 32'(wcyc[3] + 1));
        end
        check_eq({tag, "_done"}, 32'(n_done), 32'd1);
        check_eq({tag, "_err"},  32'(n_err), 32'd0);
        check_eq({tag, "_wc"},   32'(word_count), 32'd4);
        check_eq({tag, "_viol"}, 32'(viol), 32'd0);
        check_eq({tag, "_rdwrb_idle"}, 32'(icap_rdwrb), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        s_axis_tdata = 32'd0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        s_axis_tuser = 1'b0;
        clear_mon();
        repeat (3) tick();
        rst = 1'b0;
        check_eq("rst_csib",   32'(icap_csib), 32'd1);
        check_eq("rst_rdwrb",  32'(icap_rdwrb), 32'd1);
        check_eq("rst_icap",   icap_i, 32'd0);
        check_eq("rst_tready", 32'(s_axis_tready), 32'd0);
        check_eq("rst_busy",   32'(busy), 32'd0);
        check_eq("rst_done",   32'(done), 32'd0);
        check_eq("rst_error",  32'(error), 32'd0);
        check_eq("rst_wc",     32'(word_count), 32'd0);

        // Continuous 4-word frame.
        clear_mon();
        start_checked(32'h01020304);
        clean_frame("t1");
        if (wcyc.size() == 4) check_eq("t1_contig", 32'(wcyc[3] - wcyc[0]), 32'd3);

        // Same frame with a 2-cycle gap after word 2.
        clear_mon();
        enable = 1'b1;
        send_beat(32'h01020304, 1'b0, 1'b0);
        send_beat(32'h05060708, 1'b0, 1'b0);
        repeat (2) tick();
        send_beat(32'h090A0B0C, 1'b0, 1'b0);
        send_beat(32'h0000000F, 1'b1, 1'b0);
        repeat (4) tick();
        check_eq("t2_nw", 32'(wq.size()), 32'd4);
        if (wcyc.size() == 4) check_eq("t2_gap", 32'(wcyc[2] - wcyc[1]), 32'd3);
        if (wq.size() == 4) check_eq("t2_w3", wq[3], 32'h000000F0);
        check_eq("t2_done", 32'(n_done), 32'd1);
        check_eq("t2_wc",   32'(word_count), 32'd4);
        check_eq("t2_viol", 32'(viol), 32'd0);

        // Bad frame: tuser on word 3 of 6.
        clear_mon();
        send_beat(32'h01020304, 1'b0, 1'b0);
        send_beat(32'h05060708, 1'b0, 1'b0);
        send_beat(32'h090A0B0C, 1'b0, 1'b1);
        send_beat(32'h0000000F, 1'b0, 1'b0);
        send_beat(32'h11111111, 1'b0, 1'b0);
        send_beat(32'h22222222, 1'b1, 1'b0);
        repeat (4) tick();
        check_eq("t3_nw", 32'(wq.size()), 32'd2);
        if (wq.size() >= 2) check_eq("t3_w1", wq[1], 32'hA060E010);
        check_eq("t3_err",  32'(n_err), 32'd1);
        check_eq("t3_done", 32'(n_done), 32'd0);
        check_eq("t3_wc",   32'(word_count), 32'd2);
        check_eq("t3_busy", 32'(busy), 32'd0);

        // Reset mid-frame, then a clean frame.
        clear_mon();
        send_beat(32'h01020304, 1'b0, 1'b0);
        send_beat(32'h05060708, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("t4_csib",   32'(icap_csib), 32'd1);
        check_eq("t4_rdwrb",  32'(icap_rdwrb), 32'd1);
        check_eq("t4_busy",   32'(busy), 32'd0);
        check_eq("t4_tready", 32'(s_axis_tready), 32'd0);
        repeat (4) tick();
        check_eq("t4_nodone", 32'(n_done + n_err), 32'd0);
        clear_mon();
        clean_frame("t4b");

        // enable low holds the block in IDLE.
        clear_mon();
        enable = 1'b0;
        s_axis_tdata = 32'h11223344;
        s_axis_tlast = 1'b1;
        s_axis_tvalid = 1'b1;
        repeat (20) tick();
        check_eq("t5_ready_seen", 32'(ready_seen), 32'd0);
        check_eq("t5_busy", 32'(busy), 32'd0);
        enable = 1'b1;
        tick();
        check_eq("t5_setup_busy",   32'(busy), 32'd1);
        check_eq("t5_setup_tready", 32'(s_axis_tready), 32'd0);
        send_beat(32'h11223344, 1'b1, 1'b0);
        repeat (4) tick();
        if (wq.size() >= 1) check_eq("t5_w0", wq[0], 32'h8844CC22);
        check_eq("t5_done", 32'(n_done), 32'd1);
        check_eq("t5_wc",   32'(word_count), 32'd1);

        // Sync-word frame.
        clear_mon();
        send_beat(32'hFFFFFFFF, 1'b0, 1'b0);
        send_beat(32'h000000BB, 1'b0, 1'b0);
        send_beat(32'hAA995566, 1'b0, 1'b0);
        send_beat(32'h20000000, 1'b1, 1'b0);
        repeat (4) tick();
`ifdef AXIS_ICAP_SYNC_DETECT_EN
        check_eq("t6_nw", 32'(wq.size()), 32'd2);
        if (wq.size() == 2) begin
            check_eq("t6_w0", wq[0], 32'h5599AA66);
            check_eq("t6_w1", wq[1], 32'h04000000);
        end
        check_eq("t6_wc",   32'(word_count), 32'd2);
        check_eq("t6_done", 32'(n_done), 32'd1);
        clear_mon();
        send_beat(32'h01020304, 1'b0, 1'b0);
        send_beat(32'h0000000F, 1'b1, 1'b0);
        repeat (4) tick();
        check_eq("t6n_nw",  32'(wq.size()), 32'd0);
        check_eq("t6n_err", 32'(n_err), 32'd1);
        check_eq("t6n_wc",  32'(word_count), 32'd0);
`else
        check_eq("t6_nw", 32'(wq.size()), 32'd4);
        if (wq.size() == 4) check_eq("t6_w0", wq[0], 32'hFFFFFFFF);
        check_eq("t6_wc",   32'(word_count), 32'd4);
        check_eq("t6_done", 32'(n_done), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
